ucode_step_sequencer: RTL



---
 rtl/ucode_step_sequencer_pkg.sv | 23 ++
 rtl/ucode_step_sequencer_if.sv | 35 +++
 rtl/ucode_step_sequencer_ram.sv | 27 ++
 rtl/ucode_step_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ucode_step_sequencer_pkg.sv
// Shared definitions for the microcoded step sequencer: FSM state encoding,
// table row numbering and control-table entry field positions.
package ucode_step_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } seq_state_e;

  // Row 0 of the table holds the fetch sequence; opcode k lives in row k+1.
  localparam int FETCH_ROW = 0;

  // An entry is {last, memwait, ctrl[cw-1:0]}.
  function automatic int last_bit(input int cw);
    return cw + 1;
  endfunction

  function automatic int memwait_bit(input int cw);
    return cw;
  endfunction

endpackage

// File: rtl/ucode_step_sequencer_if.sv
// Control/programming bundle between the datapath controller and the
// step sequencer.
interface ucode_step_sequencer_if #(
  parameter int CW     = 32,
  parameter int NSTEPS = 8,
  parameter int OPW    = 5
);
  localparam int STW = $clog2(NSTEPS);
  localparam int AW  = OPW + 1 + STW;

  logic              run;
  logic              stop;
  logic [OPW-1:0]    ir_opcode;
  logic              mem_ready;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [CW+1:0]     prog_data;
  logic [CW-1:0]     ctrl;
  logic [STW-1:0]    step;
  logic              busy;
  logic              done;
  logic              illegal;
  logic [31:0]       instr_count;

  modport master (
    output run, stop, ir_opcode, mem_ready, prog_we, prog_addr, prog_data,
    input  ctrl, step, busy, done, illegal, instr_count
  );

  modport slave (
    input  run, stop, ir_opcode, mem_ready, prog_we, prog_addr, prog_data,
    output ctrl, step, busy, done, illegal, instr_count
  );

endinterface

// File: rtl/ucode_step_sequencer_ram.sv
// Microcode table storage: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module ucode_ram #(
  parameter int DEPTH = 264,
  parameter int AW    = 9,
  parameter int DW    = 34
) (
  input  logic          Clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port; addresses past the last row are dropped.
  always_ff @(posedge Clock) begin
    if (we && (waddr < AW'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ucode_step_sequencer.sv
// Programmable control-step sequencer: walks the shared fetch row, then the
// execute row chosen by the IR opcode, emitting one registered control word
// per step and stalling memory-wait steps until mem_ready.
module ucode_step_sequencer
  import ucode_step_sequencer_pkg::*;
#(
  parameter int CW     = 32,
  parameter int NSTEPS = 8,
  parameter int OPW    = 5
) (
  input logic                   Clock,
  input logic                   clear,
  ucode_step_sequencer_if.slave bus
);

  localparam int STW         = $clog2(NSTEPS);
  localparam int ROWW        = OPW + 1;
  localparam int AW          = ROWW + STW;
  localparam int EW          = CW + 2;
  localparam int DEPTH       = (2**OPW + 1) * NSTEPS;
  localparam int LAST_BIT    = last_bit(CW);
  localparam int MEMWAIT_BIT = memwait_bit(CW);

  seq_state_e      state_q, state_d;
  logic [ROWW-1:0] row_q, row_d;
  logic [STW-1:0]  step_q, step_d;
  logic [CW-1:0]   ctrl_q;
  logic            last_q, mwait_q;
  logic            stop_q, stop_d;
  logic            done_q, done_d;
  logic            illegal_q, set_illegal;
  logic [31:0]     count_q, count_d;

  logic            wr_en;
  logic [AW-1:0]   nxt_addr;
  logic [EW-1:0]   rd_data, entry_d;
  logic            advance, end_row;

  assign wr_en    = bus.prog_we && (state_q == ST_IDLE);
  assign nxt_addr = {row_d, step_d};

  ucode_ram #(.DEPTH(DEPTH), .AW(AW), .DW(EW)) u_ram (
    .Clock (Clock),
    .we    (wr_en),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (nxt_addr),
    .rdata (rd_data)
  );

  // A write landing on the entry being loaded this edge is forwarded so a
  // same-cycle program+run sees the new data.
  assign entry_d = (wr_en && (bus.prog_addr == nxt_addr)) ? bus.prog_data : rd_data;

  // The registered entry fields describe the step currently on the strobes.
  assign advance = !(mwait_q && !bus.mem_ready);
  assign end_row = last_q || (step_q == STW'(NSTEPS - 1));

  // Next-state: stepping, row changes, stop latch and completion accounting.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    step_d      = step_q;
    stop_d      = stop_q;
    done_d      = 1'b0;
    set_illegal = 1'b0;
    count_d     = count_q;
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (bus.run) begin
          state_d = ST_FETCH;
          row_d   = ROWW'(FETCH_ROW);
          step_d  = '0;
        end
      end
      ST_FETCH, ST_EXEC: begin
        stop_d = stop_q | bus.stop;
        if (advance) begin
          if (!end_row) begin
            step_d = step_q + STW'(1);
          end else begin
            set_illegal = !last_q;
            step_d      = '0;
            if (state_q == ST_FETCH) begin
              state_d = ST_EXEC;
              row_d   = {1'b0, bus.ir_opcode} + ROWW'(1);
            end else begin
              done_d  = 1'b1;
              count_d = count_q + 32'd1;
              row_d   = ROWW'(FETCH_ROW);
              state_d = stop_d ? ST_IDLE : ST_FETCH;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        row_d   = ROWW'(FETCH_ROW);
        step_d  = '0;
      end
    endcase
  end

  // State, step and control-word registers; clear forces an immediate idle.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      step_q    <= '0;
      ctrl_q    <= '0;
      last_q    <= 1'b0;
      mwait_q   <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      step_q    <= step_d;
      if (state_d == ST_IDLE) begin
        ctrl_q  <= '0;
        last_q  <= 1'b0;
        mwait_q <= 1'b0;
        stop_q  <= 1'b0;
      end else begin
        ctrl_q  <= entry_d[CW-1:0];
        last_q  <= entry_d[LAST_BIT];
        mwait_q <= entry_d[MEMWAIT_BIT];
        stop_q  <= stop_d;
      end
      done_q    <= done_d;
      illegal_q <= illegal_q | set_illegal;
      count_q   <= count_d;
    end
  end

  assign bus.ctrl        = ctrl_q;
  assign bus.step        = step_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;

endmodule
